// File: rtl/msdap_pkg.sv
// Shared MSDAP definitions: accumulator opcodes, sequencer state encoding and default sizes.
package msdap_pkg;

  localparam int NRJ_DEF = 16;
  localparam int CAW_DEF = 9;
  localparam int XAW_DEF = 8;

  localparam logic [1:0] ACC_NOP   = 2'b00;
  localparam logic [1:0] ACC_ACC   = 2'b01;
  localparam logic [1:0] ACC_SHIFT = 2'b10;
  localparam logic [1:0] ACC_CLR   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_RJ_WAIT,
    ST_RJ_LOAD,
    ST_MAC,
    ST_SHIFT,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/msdap_tap_index.sv
// Turns a coefficient word into a sample-buffer address relative to the newest sample.
module msdap_tap_index
  import msdap_pkg::*;
#(
  parameter int XAW = XAW_DEF
) (
  input  logic [15:0]    xc,
  input  logic [8:0]     coeff_data,
  output logic           idx_neg,
  output logic [XAW-1:0] x_addr,
  output logic           x_neg
);

  logic [15:0] idx;
  logic        unused_mid;

  assign idx        = xc - {8'h00, coeff_data[7:0]};
  // bit 15 set means the tap reaches back before the first sample ever written
  assign idx_neg    = idx[15];
  assign x_addr     = idx[XAW-1:0];
  assign x_neg      = coeff_data[8];
  assign unused_mid = ^idx[14:XAW];

endmodule

// File: rtl/msdap_conv_sequencer.sv
// Drives the shared u/y accumulator through all rj groups for L then R on each new sample pair.
module msdap_conv_sequencer
  import msdap_pkg::*;
#(
  parameter int NRJ = NRJ_DEF,
  parameter int CAW = CAW_DEF,
  parameter int XAW = XAW_DEF
) (
  input  logic                    Sclk,
  input  logic                    Reset_n,
  input  logic                    sample_vld,
  input  logic [15:0]             x_count,
  input  logic                    flush,
  output logic [$clog2(NRJ)-1:0]  rj_addr,
  input  logic [15:0]             rj_data,
  output logic [CAW-1:0]          coeff_addr,
  input  logic [15:0]             coeff_data,
  output logic                    ch_sel,
  output logic [1:0]              acc_op,
  output logic [XAW-1:0]          x_addr,
  output logic                    x_neg,
  output logic                    out_vld_l,
  output logic                    out_vld_r,
  output logic                    busy,
  output logic                    overrun,
  output logic                    cfg_err
);

  localparam int JW = $clog2(NRJ);
  localparam logic [JW-1:0] J_LAST = JW'(NRJ - 1);

  seq_state_t     state;
  logic [15:0]    xc;
  logic [JW-1:0]  j;
  logic [15:0]    k;
  logic [15:0]    kmax;
  logic [CAW-1:0] cp;

  logic           idx_neg;
  logic [XAW-1:0] tap_addr;
  logic           tap_neg;
  logic           unused_coeff;

  assign unused_coeff = ^coeff_data[15:9];

  msdap_tap_index #(.XAW(XAW)) u_tap (
    .xc        (xc),
    .coeff_data(coeff_data[8:0]),
    .idx_neg   (idx_neg),
    .x_addr    (tap_addr),
    .x_neg     (tap_neg)
  );

  always_ff @(negedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= ST_IDLE;
      xc         <= '0;
      j          <= '0;
      k          <= '0;
      kmax       <= '0;
      cp         <= '0;
      rj_addr    <= '0;
      coeff_addr <= '0;
      ch_sel     <= 1'b0;
      acc_op     <= ACC_NOP;
      x_addr     <= '0;
      x_neg      <= 1'b0;
      out_vld_l  <= 1'b0;
      out_vld_r  <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      acc_op    <= ACC_NOP;
      x_addr    <= '0;
      x_neg     <= 1'b0;
      out_vld_l <= 1'b0;
      out_vld_r <= 1'b0;
      // busy stays up through the out_vld_r cycle, so a sample landing there is also refused
      if (sample_vld && (state != ST_IDLE || busy))
        overrun <= 1'b1;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (sample_vld && !busy) begin
              xc     <= x_count;
              ch_sel <= 1'b0;
              busy   <= 1'b1;
              state  <= ST_CLR;
            end else begin
              busy <= 1'b0;
            end
          end
          ST_CLR: begin
            acc_op  <= ACC_CLR;
            cp      <= '0;
            j       <= '0;
            rj_addr <= '0;
            state   <= ST_RJ_WAIT;
          end
          ST_RJ_WAIT: state <= ST_RJ_LOAD;
          ST_RJ_LOAD: begin
            kmax       <= rj_data;
            coeff_addr <= cp;
            k          <= '0;
            state      <= (rj_data == 16'd0) ? ST_SHIFT : ST_MAC;
          end
          ST_MAC: begin
            if (!idx_neg) begin
              acc_op <= ACC_ACC;
              x_addr <= tap_addr;
              x_neg  <= tap_neg;
            end
            cp         <= cp + CAW'(1);
            coeff_addr <= cp + CAW'(1);
            if (cp == {CAW{1'b1}})
              cfg_err <= 1'b1;
            if (k == kmax - 16'd1)
              state <= ST_SHIFT;
            else
              k <= k + 16'd1;
          end
          ST_SHIFT: begin
            acc_op <= ACC_SHIFT;
            if (j == J_LAST) begin
              state <= ST_DONE;
            end else begin
              j       <= j + JW'(1);
              rj_addr <= j + JW'(1);
              state   <= ST_RJ_WAIT;
            end
          end
          ST_DONE: begin
            if (!ch_sel) begin
              out_vld_l <= 1'b1;
              ch_sel    <= 1'b1;
              state     <= ST_CLR;
            end else begin
              out_vld_r <= 1'b1;
              state     <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_msdap_conv_sequencer.sv
// Scoreboard bench: a timeline model queues every expected accumulator command and out_vld pulse.
module tb_msdap_conv_sequencer;
  import msdap_pkg::*;

  logic        Sclk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        sample_vld = 1'b0;
  logic [15:0] x_count = '0;
  logic        flush = 1'b0;
  logic [3:0]  rj_addr;
  logic [15:0] rj_data;
  logic [8:0]  coeff_addr;
  logic [15:0] coeff_data;
  logic        ch_sel;
  logic [1:0]  acc_op;
  logic [7:0]  x_addr;
  logic        x_neg;
  logic        out_vld_l, out_vld_r, busy, overrun, cfg_err;

  msdap_conv_sequencer dut (
    .Sclk(Sclk), .Reset_n(Reset_n), .sample_vld(sample_vld), .x_count(x_count), .flush(flush),
    .rj_addr(rj_addr), .rj_data(rj_data), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .ch_sel(ch_sel), .acc_op(acc_op), .x_addr(x_addr), .x_neg(x_neg),
    .out_vld_l(out_vld_l), .out_vld_r(out_vld_r), .busy(busy), .overrun(overrun), .cfg_err(cfg_err)
  );

  always #5 Sclk = ~Sclk;

  logic [15:0] rj_mem [16];
  logic [15:0] coeff_mem [512];

  // memories answer on the opposite edge, so data is ready by the next sequencer edge
  always @(posedge Sclk) begin
    rj_data    <= rj_mem[rj_addr];
    coeff_data <= coeff_mem[coeff_addr];
  end

  int cyc = 0;
  always @(negedge Sclk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] cyc;
    logic [1:0]  op;
    logic        ch;
    logic [7:0]  xa;
    logic        neg;
    logic        vl;
    logic        vr;
  } ev_t;

  ev_t sb[$];
  ev_t got_ev, exp_ev;
  int  n_total = 0;
  int  n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input logic [1:0] op, input logic ch,
                               input logic [7:0] xa, input logic neg, input logic vl, input logic vr);
    ev_t e;
    e.cyc = 32'(c); e.op = op; e.ch = ch; e.xa = xa; e.neg = neg; e.vl = vl; e.vr = vr;
    sb.push_back(e);
  endfunction

  // State at cycle t (cycle 1 = first after accept) shows its command at cycle t+1, i.e. cyc n0+t.
  task automatic gen_seq(input int n0, input logic [15:0] xc, output int total);
    int t;
    t = 1;
    for (int ch = 0; ch < 2; ch++) begin
      int cp;
      cp = 0;
      push(n0 + t, ACC_CLR, ch[0], 8'd0, 1'b0, 1'b0, 1'b0); t++;
      for (int jj = 0; jj < 16; jj++) begin
        t += 2;
        for (int kk = 0; kk < int'(rj_mem[jj]); kk++) begin
          logic [15:0] idx;
          idx = xc - {8'h00, coeff_mem[cp][7:0]};
          if (!idx[15]) push(n0 + t, ACC_ACC, ch[0], idx[7:0], coeff_mem[cp][8], 1'b0, 1'b0);
          cp = (cp + 1) % 512;
          t++;
        end
        push(n0 + t, ACC_SHIFT, ch[0], 8'd0, 1'b0, 1'b0, 1'b0); t++;
      end
      push(n0 + t, ACC_NOP, 1'b1, 8'd0, 1'b0, ch == 0, ch == 1);
      if (ch == 1) total = t;
      t++;
    end
  endtask

  always @(posedge Sclk) begin
    if (Reset_n && (acc_op != ACC_NOP || out_vld_l || out_vld_r)) begin
      got_ev = '{cyc: 32'(cyc), op: acc_op, ch: ch_sel, xa: x_addr, neg: x_neg, vl: out_vld_l, vr: out_vld_r};
      if (sb.size() == 0) begin
        chk("unexpected_cmd", 64'(got_ev), 64'(0));
      end else begin
        exp_ev = sb.pop_front();
        chk("acc_cmd", 64'(got_ev), 64'(exp_ev));
      end
      if (out_vld_r) chk("busy_at_vld_r", 64'(busy), 64'(1));
    end
  end

  task automatic tick();
    @(negedge Sclk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) tick();
  endtask

  task automatic set_rj(input int v);
    for (int i = 0; i < 16; i++) rj_mem[i] = 16'(v);
  endtask

  task automatic start(input logic [15:0] xc, output int n0, output int total);
    x_count    = xc;
    sample_vld = 1'b1;
    n0         = cyc + 1;
    gen_seq(n0, xc, total);
    tick();
    sample_vld = 1'b0;
  endtask

  // out_vld_r shows at cyc n0+total; busy covers that cycle and drops right after
  task automatic drain(input string tag, input int n0, input int total);
    wait_until(n0 + total);
    chk({tag, "_busy_last"}, 64'(busy), 64'(1));
    tick();
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    repeat (3) tick();
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'(0));
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({rj_addr, coeff_addr, ch_sel, acc_op, x_addr, x_neg, out_vld_l, out_vld_r, busy, overrun, cfg_err});
  endfunction

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1);
  end

  initial begin
    int n0, total;
    for (int i = 0; i < 512; i++) coeff_mem[i] = 16'((((i >> 1) & 1) << 8) | (i & 255));
    set_rj(1);
    repeat (3) tick();
    chk("reset_outs", all_outs(), 64'(0));
    Reset_n = 1'b1;
    tick();

    // 1: one tap per group, newest sample 20
    start(16'd20, n0, total);
    chk("t1_busy_start", 64'(busy), 64'(1));
    chk("t1_len", 64'(total), 64'(132));
    drain("t1", n0, total);

    // 2: early taps before the first sample turn into NOPs
    set_rj(0); rj_mem[0] = 16'd6;
    start(16'd2, n0, total);
    drain("t2", n0, total);

    // 3: empty first/last groups; x_count with bit 15 set
    set_rj(2); rj_mem[0] = 16'd0; rj_mem[15] = 16'd0;
    start(16'h8003, n0, total);
    drain("t3", n0, total);

    // 4: samples arriving while busy, including the R DONE cycle
    set_rj(1);
    start(16'd300, n0, total);
    wait_until(n0 + 39);
    chk("t4_overrun_before", 64'(overrun), 64'(0));
    x_count = 16'd5; sample_vld = 1'b1; tick(); sample_vld = 1'b0;
    chk("t4_overrun_mid", 64'(overrun), 64'(1));
    wait_until(n0 + 131);
    sample_vld = 1'b1; tick(); sample_vld = 1'b0;
    drain("t4", n0, total);
    chk("t4_overrun_sticky", 64'(overrun), 64'(1));

    // 5: async reset during L MAC, then a clean sample
    start(16'd50, n0, total);
    wait_until(n0 + 19);
    #2 Reset_n = 1'b0;
    sb.delete();
    #1 chk("t5_reset_outs", all_outs(), 64'(0));
    tick();
    Reset_n = 1'b1;
    tick();
    chk("t5_idle_busy", 64'(busy), 64'(0));
    start(16'd7, n0, total);
    drain("t5", n0, total);

    // 6: flush during the R SHIFT of group 3
    start(16'd40, n0, total);
    wait_until(n0 + 82);
    flush = 1'b1;
    while (sb.size() > 0 && int'(sb[$].cyc) >= n0 + 83) void'(sb.pop_back());
    tick();
    flush = 1'b0;
    chk("t6_busy_after_flush", 64'(busy), 64'(0));
    repeat (10) tick();
    chk("t6_sb_empty", 64'(sb.size()), 64'(0));

    // 7: 520 taps in one group wraps the coefficient pointer
    set_rj(0); rj_mem[0] = 16'd520;
    chk("t7_cfg_err_before", 64'(cfg_err), 64'(0));
    start(16'd300, n0, total);
    wait_until(n0 + 514);
    chk("t7_caddr_511", 64'(coeff_addr), 64'(511));
    chk("t7_cfg_err_pre", 64'(cfg_err), 64'(0));
    tick();
    chk("t7_caddr_wrap", 64'(coeff_addr), 64'(0));
    chk("t7_cfg_err_set", 64'(cfg_err), 64'(1));
    drain("t7", n0, total);
    chk("t7_cfg_err_sticky", 64'(cfg_err), 64'(1));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
